// File: rtl/seq_recognizer_moore_param.sv
// Moore recognizer for a runtime-loadable PAT_W-bit serial pattern, overlapping or not.
// Define LAB_SEG_DISPLAY_EN to build the registered 7-segment decode of match_cnt.
module seq_recognizer_moore_param #(
    parameter int PAT_W = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int HIST_W = 3,
    parameter int CNT_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              in,
    input  logic              overlap,
    input  logic [PAT_W-1:0]  pat,
    input  logic              pat_load,
    input  logic              cnt_clr,
    output logic [HIST_W-1:0] past,
    output logic              out,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [6:0]        display
);

    localparam int SW = $clog2(PAT_W + 1);
    localparam logic [SW-1:0] DETECT = SW'(PAT_W);

    logic [SW-1:0]    state;
    logic [SW-1:0]    state_next;
    logic [PAT_W-1:0] pat_reg;
    logic             hit;

    // Longest pattern prefix that is a suffix of (first k pattern bits, b).
    // s holds that k+1 bit string right-aligned; candidate j compares its low j bits
    // against the top j bits of the pattern.
    function automatic logic [SW-1:0] kmp_next(input logic [SW-1:0] k, input logic b,
                                               input logic [PAT_W-1:0] p);
        logic [SW-1:0] best;
        logic [PAT_W:0] s;
        logic [PAT_W:0] mask;
        logic [PAT_W:0] pre;
        best = '0;
        s = {1'b0, p} >> (PAT_W - int'(k));
        s = (s << 1) | {{PAT_W{1'b0}}, b};
        for (int j = 1; j <= PAT_W; j++) begin
            if (j <= int'(k) + 1) begin
                mask = {(PAT_W + 1){1'b1}} >> (PAT_W + 1 - j);
                pre  = {1'b0, p} >> (PAT_W - j);
                if ((s & mask) == pre) best = SW'(j);
            end
        end
        return best;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= '0;
            pat_reg <= PATTERN;
        end else begin
            state <= state_next;
            if (pat_load) pat_reg <= pat;
        end
    end

    always_comb begin
        state_next = state;
        hit        = 1'b0;
        if (pat_load) begin
            state_next = '0;
        end else if (en) begin
            // Non-overlapping mode discards the matched history when leaving DETECT.
            if (state == DETECT && !overlap)
                state_next = kmp_next('0, in, pat_reg);
            else
                state_next = kmp_next(state, in, pat_reg);
            hit = (state_next == DETECT);
        end
    end

    always_comb begin
        out = (state == DETECT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            match_cnt <= '0;
        else if (cnt_clr)
            match_cnt <= '0;
        else if (hit && match_cnt != {CNT_W{1'b1}})
            match_cnt <= match_cnt + 1'b1;
    end

    generate
        if (HIST_W == 1) begin : g_hist1
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)  past <= '0;
                else if (en) past <= in;
            end
        end else begin : g_histn
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)  past <= '0;
                else if (en) past <= {past[HIST_W-2:0], in};
            end
        end
    endgenerate

`ifdef LAB_SEG_DISPLAY_EN
    // Segment order {a,b,c,d,e,f,g}, active-high.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'b1111110;
            4'h1: seg7 = 7'b0110000;
            4'h2: seg7 = 7'b1101101;
            4'h3: seg7 = 7'b1111001;
            4'h4: seg7 = 7'b0110011;
            4'h5: seg7 = 7'b1011011;
            4'h6: seg7 = 7'b1011111;
            4'h7: seg7 = 7'b1110000;
            4'h8: seg7 = 7'b1111111;
            4'h9: seg7 = 7'b1111011;
            4'hA: seg7 = 7'b1110111;
            4'hB: seg7 = 7'b0011111;
            4'hC: seg7 = 7'b1001110;
            4'hD: seg7 = 7'b0111101;
            4'hE: seg7 = 7'b1001111;
            default: seg7 = 7'b1000111;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) display <= 7'b1111110;
        else        display <= seg7(match_cnt[3:0]);
    end
`else
    assign display = 7'b0000000;
`endif

endmodule
